// File: rtl/bcd_convert_seq_if.sv
// Start/busy/done handshake and result bus between a binary source and bcd_convert_seq.
// Master drives the request; slave returns status and the packed BCD result.
interface bcd_convert_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [31:0]      bcd;
  logic             overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_convert_seq.sv
// Iterative double-dabble binary-to-BCD converter feeding the 8-digit display driver.
// Optional BCD_CONVERT_SAT_EN: overflowing results saturate the display to 99999999.
module bcd_convert_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  bcd_convert_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t           state;
  logic [39:0]      acc;
  logic [39:0]      acc_adj;
  logic [WIDTH-1:0] sreg;
  logic [5:0]       cnt;
  logic             result_ovf;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < 10; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
  end

  assign result_ovf = |acc[39:32];

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      sreg         <= '0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.bcd      <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sreg     <= bus.bin;
            acc      <= '0;
            cnt      <= 6'(WIDTH);
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Correct all digits first, then shift the next binary bit into digit0.
          acc  <= {acc_adj[38:0], sreg[WIDTH-1]};
          sreg <= sreg << 1;
          cnt  <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state <= FINISH;
          end
        end
        FINISH: begin
`ifdef BCD_CONVERT_SAT_EN
          bus.bcd <= result_ovf ? 32'h9999_9999 : acc[31:0];
`else
          bus.bcd <= acc[31:0];
`endif
          bus.overflow <= result_ovf;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed-vector bench for bcd_convert_seq (WIDTH=32), hand-computed BCD expectations.
// Build with +define+BCD_CONVERT_SAT_EN to check the saturating variant.
module tb_bcd_convert_seq;

  localparam int WIDTH = 32;

`ifdef BCD_CONVERT_SAT_EN
  localparam logic [31:0] OVF_100M = 32'h9999_9999;
  localparam logic [31:0] OVF_MAX  = 32'h9999_9999;
`else
  localparam logic [31:0] OVF_100M = 32'h0000_0000;
  localparam logic [31:0] OVF_MAX  = 32'h9496_7295;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] last_bcd = '0;

  bcd_convert_seq_if #(.WIDTH(WIDTH)) bus ();

  bcd_convert_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Full conversion: start pulse, then latency, busy, mid-run hold and result checks.
  task automatic convert(input logic [31:0] value, input logic [31:0] exp_bcd, input logic exp_ovf);
    int lat;
    int busy_lo;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = value;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = $urandom;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    lat     = 0;
    busy_lo = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!bus.done && !bus.busy) busy_lo++;
      if (lat == 16) check("bcd_hold_midway", bus.bcd, last_bcd);
    end
    check("latency", 32'(lat), 32'd33);
    check("busy_whole_run", 32'(busy_lo), 32'd0);
    check("bcd", bus.bcd, exp_bcd);
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
    check("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    last_bcd = exp_bcd;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.done && cycles < 100);
  endtask

  initial begin
    int cyc;
    int n_done;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_bcd", bus.bcd, 32'd0);
    check("reset_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;

    convert(32'd12345678,  32'h1234_5678, 1'b0);
    convert(32'd0,         32'h0000_0000, 1'b0);
    convert(32'd99999999,  32'h9999_9999, 1'b0);
    convert(32'd9,         32'h0000_0009, 1'b0);
    convert(32'd10,        32'h0000_0010, 1'b0);
    convert(32'd1000,      32'h0000_1000, 1'b0);
    convert(32'd100000000, OVF_100M,      1'b1);
    convert(32'hFFFF_FFFF, OVF_MAX,       1'b1);
    convert(32'd90071992,  32'h9007_1992, 1'b0);

    // Start while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 32'd42;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    n_done = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("ignored_start_dones", 32'(n_done), 32'd1);
    check("ignored_start_bcd", bus.bcd, 32'h0000_0042);

    // Start held high: back-to-back conversions every WIDTH+2 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 32'd2024;
    wait_done(cyc);
    check("held_first_done", 32'(bus.done), 32'd1);
    wait_done(cyc);
    check("held_period_1", 32'(cyc), 32'd34);
    wait_done(cyc);
    check("held_period_2", 32'(cyc), 32'd34);
    bus.start = 1'b0;
    check("held_bcd", bus.bcd, 32'h0000_2024);
    repeat (3) @(negedge clk);
    check("held_released_idle", 32'(bus.busy), 32'd0);

    // Reset mid-conversion abandons the run without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 32'd555;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_bcd", bus.bcd, 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    last_bcd = '0;
    convert(32'd555, 32'h0000_0555, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
